// File: rtl/alu_seq_driver.sv
// alu_seq_driver: sweeps all 256 packed operand words {sel,B,A} into an
// external 3-bit ALU. Each word is held for SETTLE cycles and then the
// result is sampled once. Sampled results are folded into a 16-bit LFSR
// signature.
// Optional build macro ALU_SEQ_FMT_CHECK_EN adds a saturating counter.
// It counts result words whose reserved bits are nonzero. Without the
// macro, fmt_err_cnt is tied to zero.
module alu_seq_driver #(
  parameter int unsigned SETTLE = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        abort,
  output logic [7:0]  op_out,
  output logic        op_valid,
  input  logic [7:0]  res_in,
  output logic        busy,
  output logic        done,
  output logic [15:0] sig_out,
  output logic [7:0]  fmt_err_cnt
);

  typedef enum logic [1:0] {IDLE, DRIVE, SAMPLE, FIN} state_t;

  // Result word layout: reserved bits around Y and Cout.
  typedef struct packed {
    logic [2:0] rsvd_hi;
    logic       cout;
    logic       rsvd_lo;
    logic [2:0] y;
  } res_t;

  localparam logic [3:0] WLAST = 4'(SETTLE - 1);

  state_t      state;
  logic [7:0]  idx;
  logic [3:0]  wcnt;
  logic [15:0] sig;
  res_t        res;
  logic        sweep_go;
  logic        smp_fire;

  assign res      = res_in;
  assign sig_out  = sig;
  // An accepted start is one that arrives in IDLE with abort low.
  assign sweep_go = (state == IDLE) && start && !abort;
  // SAMPLE only commits when abort is low. An abort here drops the sample.
  assign smp_fire = (state == SAMPLE) && !abort;

  function automatic logic [15:0] sig_step(input logic [15:0] s, input res_t r);
    logic fb;
    fb = s[15] ^ s[14] ^ s[12] ^ s[3];
    return {s[14:0], fb} ^ {11'b0, r.cout, 1'b0, r.y};
  endfunction

  // Sequencer FSM with registered operand, handshake and signature outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      idx      <= 8'h00;
      wcnt     <= 4'h0;
      sig      <= 16'h0000;
      op_out   <= 8'h00;
      op_valid <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (sweep_go) begin
            idx      <= 8'h00;
            wcnt     <= 4'h0;
            sig      <= 16'h0000;
            op_out   <= 8'h00;
            op_valid <= 1'b1;
            busy     <= 1'b1;
            state    <= DRIVE;
          end
        end
        DRIVE: begin
          if (abort) begin
            wcnt     <= 4'h0;
            op_out   <= 8'h00;
            op_valid <= 1'b0;
            busy     <= 1'b0;
            state    <= IDLE;
          end else if (wcnt == WLAST) begin
            wcnt  <= 4'h0;
            state <= SAMPLE;
          end else begin
            wcnt <= wcnt + 4'h1;
          end
        end
        SAMPLE: begin
          if (abort) begin
            op_out   <= 8'h00;
            op_valid <= 1'b0;
            busy     <= 1'b0;
            state    <= IDLE;
          end else begin
            sig <= sig_step(sig, res);
            if (idx == 8'hFF) begin
              // Last vector: idx stays at FF, so the sweep never wraps.
              op_out   <= 8'h00;
              op_valid <= 1'b0;
              done     <= 1'b1;
              state    <= FIN;
            end else begin
              idx    <= idx + 8'h01;
              op_out <= idx + 8'h01;
              state  <= DRIVE;
            end
          end
        end
        FIN: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef ALU_SEQ_FMT_CHECK_EN
  logic [7:0] fmt_cnt;

  // Count malformed result words. The count saturates and is cleared on an accepted start.
  always_ff @(posedge clk) begin
    if (rst)
      fmt_cnt <= 8'h00;
    else if (sweep_go)
      fmt_cnt <= 8'h00;
    else if (smp_fire && (|{res.rsvd_hi, res.rsvd_lo}) && (fmt_cnt != 8'hFF))
      fmt_cnt <= fmt_cnt + 8'h01;
  end

  assign fmt_err_cnt = fmt_cnt;
`else
  // Reserved result bits are deliberately ignored when the check is compiled out.
  logic unused_rsvd;
  assign unused_rsvd = ^{res.rsvd_hi, res.rsvd_lo, smp_fire};
  assign fmt_err_cnt = 8'h00;
`endif

endmodule

// File: tb/tb_alu_seq_driver.sv
// Scoreboard bench for alu_seq_driver.
// The stimulus process queues an expected end-of-sweep record for each
// start it issues. The monitor process compares each record when done pulses.
module tb_alu_seq_driver;
  localparam int SETTLE    = 2;
  localparam int SWEEP_LEN = 256 * (SETTLE + 1) + 1;
`ifdef ALU_SEQ_FMT_CHECK_EN
  localparam logic [7:0] FMT_SAT = 8'hFF;
`else
  localparam logic [7:0] FMT_SAT = 8'h00;
`endif

  logic        clk = 1'b0;
  logic        rst, start, abort;
  logic [7:0]  op_out, res_in, fmt_err_cnt;
  logic        op_valid, busy, done;
  logic [15:0] sig_out;
  int          res_mode;

  alu_seq_driver #(.SETTLE(SETTLE)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .op_out(op_out), .op_valid(op_valid), .res_in(res_in),
    .busy(busy), .done(done), .sig_out(sig_out), .fmt_err_cnt(fmt_err_cnt)
  );

  always #5 clk = ~clk;

  // Reference 3-bit ALU: sel 0 add, 1 subtract (borrow out), 2 and, 3 xor.
  function automatic logic [7:0] alu_model(input logic [7:0] op);
    logic [2:0] a, b;
    logic [3:0] t;
    a = op[2:0];
    b = op[5:3];
    case (op[7:6])
      2'd0:    t = {1'b0, a} + {1'b0, b};
      2'd1:    t = {1'b0, a} - {1'b0, b};
      2'd2:    t = {1'b0, a & b};
      default: t = {1'b0, a ^ b};
    endcase
    return {3'b000, t[3], 1'b0, t[2:0]};
  endfunction

  // Expected signature after the first n vectors of an ALU-model sweep.
  function automatic logic [15:0] sig_model(input int n);
    logic [15:0] s;
    logic [7:0]  r;
    s = 16'h0000;
    for (int i = 0; i < n; i++) begin
      r = alu_model(8'(i));
      s = {s[14:0], s[15] ^ s[14] ^ s[12] ^ s[3]} ^ {11'b0, r[4], 1'b0, r[2:0]};
    end
    return s;
  endfunction

  always_comb begin
    res_in = 8'h00;
    case (res_mode)
      0:       res_in = 8'h00;
      1:       res_in = alu_model(op_out);
      default: res_in = 8'h08;
    endcase
  end

  typedef struct packed {
    logic [15:0] sig;
    logic [7:0]  fmt;
  } exp_t;

  exp_t q[$];
  int   vectors     = 0;
  int   miscompares = 0;
  int   done_cnt    = 0;
  logic idle_bad    = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: track sweep length and operand sequence, and score on done.
  int   cyc = 0;
  logic seq_bad = 1'b0;
  logic prev_busy = 1'b0;
  exp_t e;
  always @(negedge clk) begin
    if (done === 1'b1) done_cnt++;
    if (busy === 1'b1) begin
      if (!prev_busy) begin
        cyc = 0;
        seq_bad = 1'b0;
      end
      cyc++;
      if (op_valid === 1'b1 && op_out !== 8'((cyc - 1) / (SETTLE + 1))) seq_bad = 1'b1;
      if (done === 1'b1) begin
        if (q.size() == 0) begin
          chk("unexpected_done", 64'd1, 64'd0);
        end else begin
          e = q.pop_front();
          chk("sweep_sig", 64'(sig_out), 64'(e.sig));
          chk("sweep_fmt", 64'(fmt_err_cnt), 64'(e.fmt));
          chk("sweep_len", 64'(cyc), 64'(SWEEP_LEN));
          chk("sweep_seq", 64'(seq_bad), 64'd0);
          chk("fin_outputs", 64'({op_valid, op_out}), 64'd0);
        end
      end
    end else if (op_valid === 1'b1 || (op_out !== 8'h00 && rst === 1'b0) || done === 1'b1) begin
      idle_bad = 1'b1;
    end
    prev_busy = (busy === 1'b1);
  end

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy !== 1'b0 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 2000) chk("wait_idle_timeout", 64'd1, 64'd0);
  endtask

  task automatic wait_op(input logic [7:0] v);
    int n = 0;
    while (op_out !== v && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 2000) chk("wait_op_timeout", 64'd1, 64'd0);
  endtask

  int d0;

  initial begin
    rst = 1'b1; start = 1'b0; abort = 1'b0; res_mode = 0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("reset_outputs", 64'({busy, done, op_valid, op_out, sig_out, fmt_err_cnt}), 64'd0);

    // Zero results: operands step 00..FF, signature stays zero.
    q.push_back('{sig: 16'h0000, fmt: 8'h00});
    pulse_start();
    chk("start_op", 64'({op_valid, op_out, sig_out}), 64'({1'b1, 8'h00, 16'h0000}));
    wait_idle();

    // ALU model results: signature must match the reference LFSR fold.
    res_mode = 1;
    q.push_back('{sig: sig_model(256), fmt: 8'h00});
    pulse_start();
    wait_idle();
    repeat (5) @(negedge clk);
    chk("sig_hold_idle", 64'(sig_out), 64'(sig_model(256)));

    // Reserved bit set on every result.
    res_mode = 2;
    q.push_back('{sig: 16'h0000, fmt: FMT_SAT});
    pulse_start();
    wait_idle();
    chk("fmt_hold_idle", 64'(fmt_err_cnt), 64'(FMT_SAT));

    // Abort at operand 10: vectors 00..0F are already folded into the signature.
    res_mode = 1;
    pulse_start();
    wait_op(8'h10);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort_idle", 64'({busy, op_valid, op_out}), 64'd0);
    chk("abort_sig_frozen", 64'(sig_out), 64'(sig_model(16)));
    d0 = done_cnt;
    repeat (10) @(negedge clk);
    chk("abort_no_done", 64'(done_cnt), 64'(d0));
    chk("abort_sig_held", 64'(sig_out), 64'(sig_model(16)));

    // Restart clears the signature. A start at operand 40 is ignored.
    q.push_back('{sig: sig_model(256), fmt: 8'h00});
    pulse_start();
    chk("restart_clear", 64'({op_valid, op_out, sig_out}), 64'({1'b1, 8'h00, 16'h0000}));
    wait_op(8'h40);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("start_ignored_busy", 64'(busy), 64'd1);
    d0 = done_cnt;
    wait_idle();
    repeat (5) @(negedge clk);
    chk("single_done", 64'(done_cnt - d0), 64'd1);

    // Start and abort together in IDLE: abort wins.
    start = 1'b1; abort = 1'b1;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    chk("start_abort_idle", 64'({busy, op_valid, op_out}), 64'd0);
    chk("start_abort_sig", 64'(sig_out), 64'(sig_model(256)));

    // Reset held for two cycles mid-sweep.
    pulse_start();
    repeat (100) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("reset_mid_1", 64'({busy, done, op_valid, op_out, sig_out, fmt_err_cnt}), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    chk("reset_mid_2", 64'({busy, done, op_valid, op_out, sig_out, fmt_err_cnt}), 64'd0);
    repeat (3) @(negedge clk);
    chk("reset_stays_idle", 64'(busy), 64'd0);

    chk("idle_outputs", 64'(idle_bad), 64'd0);
    chk("queue_empty", 64'(q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/alu_seq_driver.md
ALU_SEQ_DRIVER -- requirements
Module: alu_seq_driver

Interface
REQ-001 SHALL have parameter SETTLE, default 2, legal 1..15: cycles each operand word is held before the result is sampled.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port start  input  1  one-cycle request to run a full operand sweep.
REQ-005 SHALL have port abort  input  1  terminate a running sweep.
REQ-006 SHALL have port op_out  output  8  packed operand word: [2:0]=A, [5:3]=B, [7:6]=sel.
REQ-007 SHALL have port op_valid  output  1  high while op_out carries a live vector.
REQ-008 SHALL have port res_in  input  8  packed ALU result word: [2:0]=Y, [3]=reserved 0, [4]=Cout, [7:5]=reserved 0.
REQ-009 SHALL have port busy  output  1  high in any state other than IDLE.
REQ-010 SHALL have port done  output  1  one-cycle pulse on sweep completion.
REQ-011 SHALL have port sig_out  output  16  result signature register.
REQ-012 SHALL have port fmt_err_cnt  output  8  count of result words with nonzero reserved bits.

Function
REQ-013 SHALL implement FSM states IDLE, DRIVE, SAMPLE, FIN.
REQ-014 IDLE: start=1 and abort=0 SHALL clear idx (8-bit), sig_out and fmt_err_cnt, and enter DRIVE next cycle.
REQ-015 DRIVE SHALL drive op_out=idx with op_valid=1 for exactly SETTLE cycles (wait counter), then enter SAMPLE.
REQ-016 SAMPLE SHALL last one cycle, hold op_out=idx and op_valid=1, and register res_in that cycle.
REQ-017 In SAMPLE, sig_out SHALL update to {sig[14:0], sig[15]^sig[14]^sig[12]^sig[3]} XOR {11'b0, Cout, 1'b0, Y}, with Y=res_in[2:0] and Cout=res_in[4].
REQ-018 In SAMPLE with idx≠255, idx SHALL increment and the FSM SHALL return to DRIVE.
REQ-019 In SAMPLE with idx=255, the FSM SHALL enter FIN; idx SHALL NOT wrap into another vector.
REQ-020 FIN SHALL assert done for one cycle with op_valid=0, then enter IDLE.
REQ-021 Each vector SHALL take SETTLE+1 cycles; a sweep SHALL run from the first DRIVE cycle to the FIN cycle in 256*(SETTLE+1)+1 cycles.
REQ-022 op_out SHALL be 8'h00 and op_valid SHALL be 0 in IDLE and FIN.
REQ-023 start SHALL be ignored while busy=1.
REQ-024 abort=1 in DRIVE or SAMPLE SHALL enter IDLE next cycle: no done pulse, sig_out and fmt_err_cnt held, no SAMPLE update on that cycle.
REQ-025 start and abort both high in IDLE: abort SHALL win and the FSM SHALL stay in IDLE.
REQ-026 sig_out and fmt_err_cnt SHALL hold their final values in IDLE until the next accepted start.

Reset
REQ-027 rst=1 SHALL force, at the next edge: state IDLE, idx=0, wait counter=0, op_out=8'h00, op_valid=0, busy=0, done=0, sig_out=16'h0000, fmt_err_cnt=8'h00.
REQ-028 rst SHALL override start and abort, and mid-sweep SHALL discard all progress.

Configuration
REQ-029 Macro ALU_SEQ_FMT_CHECK_EN defined: in SAMPLE, res_in[3]|res_in[7]|res_in[6]|res_in[5]=1 SHALL increment fmt_err_cnt, saturating at 8'hFF.
REQ-030 Macro ALU_SEQ_FMT_CHECK_EN undefined: fmt_err_cnt SHALL be constant 8'h00 with no check logic, and all other behaviour SHALL be unchanged.

Verification
REQ-031 Reset: assert rst for 2 cycles mid-sweep -> all outputs at REQ-027 values next cycle, busy=0.
REQ-032 SETTLE=2, res_in tied 8'h00, start pulse -> op_out steps 00,01,...,FF each held 3 cycles; done exactly 769 cycles after the start edge; sig_out=16'h0000.
REQ-033 SETTLE=2, res_in = bench ALU model of op_out -> sig_out equals the bench-computed signature per REQ-017; fmt_err_cnt=0.
REQ-034 ALU_SEQ_FMT_CHECK_EN defined, res_in tied 8'h08 -> fmt_err_cnt=8'hFF (saturated, 256 errors); undefined -> 8'h00.
REQ-035 Abort asserted while op_out=8'h10 -> IDLE next cycle, no done pulse, sig_out frozen; a new start clears sig_out and restarts at op_out=8'h00.
REQ-036 Start pulsed at op_out=8'h40 during a sweep -> ignored; sweep still completes at 8'hFF with a single done pulse.
